ps2_scancode_decoder: RTL and testbench

Converts the raw PS/2 scan-code set 2 byte stream into discrete key events and buffers them for the RISC-V core. It sits directly downstream of the PS/2 receiver stage and takes one received byte per strobe. It collapses E0/F0/E1 prefix sequences into single events and keeps them in a first-word-fall-through FIFO. The core pops the FIFO through its peripheral read path.

---
 rtl/ps2_scancode_decoder.sv | 188 ++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: collapses E0/F0/E1 prefixes into key events in a FWFT FIFO.
// Define PS2_ASCII_EN to add ASCII translation and shift tracking on evt_data[15:8].
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK100MHZ,
  input  logic        areset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        rd_en,
  input  logic        clr_ovf,
  output logic [17:0] evt_data,
  output logic        evt_valid,
  output logic        overflow,
  output logic        shift_held,
  output logic [2:0]  fsm_state
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  skip_cnt, skip_nxt;
  logic        emit, emit_rel, emit_ext;
  logic [7:0]  emit_code;
  logic [7:0]  ascii;

  // byte_valid is a one-cycle strobe with no backpressure; rd_en pops the head only while evt_valid=1.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    emit      = 1'b0;
    emit_rel  = 1'b0;
    emit_ext  = 1'b0;
    emit_code = byte_in;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          case (byte_in)
            8'hE0: state_nxt = EXT;
            8'hF0: state_nxt = BRK;
            8'hE1: begin
              state_nxt = PAUSE;
              skip_nxt  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF: state_nxt = IDLE;
            default: emit = 1'b1;
          endcase
        end
        EXT: begin
          if (byte_in == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else begin
            emit      = 1'b1;
            emit_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          emit      = 1'b1;
          emit_rel  = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          emit      = 1'b1;
          emit_rel  = 1'b1;
          emit_ext  = 1'b1;
          state_nxt = IDLE;
        end
        PAUSE: begin
          // The whole pause sequence is reported once, as a single E1 make event.
          if (skip_cnt <= 3'd1) begin
            skip_nxt  = 3'd0;
            emit      = 1'b1;
            emit_code = 8'hE1;
            state_nxt = IDLE;
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  assign fsm_state = state;

`ifdef PS2_ASCII_EN
  function automatic logic [7:0] ascii_lookup(input logic [7:0] code, input logic shift);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = "A";  8'h32: ch = "B";  8'h21: ch = "C";  8'h23: ch = "D";
      8'h24: ch = "E";  8'h2B: ch = "F";  8'h34: ch = "G";  8'h33: ch = "H";
      8'h43: ch = "I";  8'h3B: ch = "J";  8'h42: ch = "K";  8'h4B: ch = "L";
      8'h3A: ch = "M";  8'h31: ch = "N";  8'h44: ch = "O";  8'h4D: ch = "P";
      8'h15: ch = "Q";  8'h2D: ch = "R";  8'h1B: ch = "S";  8'h2C: ch = "T";
      8'h3C: ch = "U";  8'h2A: ch = "V";  8'h1D: ch = "W";  8'h22: ch = "X";
      8'h35: ch = "Y";  8'h1A: ch = "Z";
      8'h16: ch = shift ? "!" : "1";
      8'h1E: ch = shift ? "@" : "2";
      8'h26: ch = shift ? "#" : "3";
      8'h25: ch = shift ? "$" : "4";
      8'h2E: ch = shift ? "%" : "5";
      8'h36: ch = shift ? "^" : "6";
      8'h3D: ch = shift ? "&" : "7";
      8'h3E: ch = shift ? "*" : "8";
      8'h46: ch = shift ? "(" : "9";
      8'h45: ch = shift ? ")" : "0";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    // Letters are tabled in uppercase; bit 5 selects lowercase.
    if (!shift && ch >= "A" && ch <= "Z") ch = ch | 8'h20;
    return ch;
  endfunction

  logic shift_q;

  assign ascii = emit_ext ? 8'h00 : ascii_lookup(emit_code, shift_q);

  // Tracked on every emitted shift event, even one the full FIFO drops.
  always_ff @(posedge CLK100MHZ or posedge areset) begin
    if (areset) begin
      shift_q <= 1'b0;
    end else if (emit && !emit_ext && (emit_code == 8'h12 || emit_code == 8'h59)) begin
      shift_q <= ~emit_rel;
    end
  end

  assign shift_held = shift_q;
`else
  assign ascii      = 8'h00;
  assign shift_held = 1'b0;
`endif

  logic [AW:0]  wr_ptr, rd_ptr;
  logic [17:0]  mem [FIFO_DEPTH];
  logic         empty, full, pop, push, drop;
  logic [17:0]  evt_word;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rd_en & ~empty;
  assign push     = emit & (~full | pop);
  assign drop     = emit & full & ~pop;
  assign evt_word = {emit_rel, emit_ext, ascii, emit_code};

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr[AW-1:0]] <= evt_word;
  end

  always_ff @(posedge CLK100MHZ or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign evt_valid = ~empty;
  assign evt_data  = empty ? 18'h0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: vector table, corner-case sequences and a randomized run
// against a queue-based reference model. Honours PS2_ASCII_EN when defined.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
`ifdef PS2_ASCII_EN
  localparam bit ASCII_EN = 1'b1;
`else
  localparam bit ASCII_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_ovf = 1'b0;
  logic [17:0] evt_data;
  logic        evt_valid;
  logic        overflow;
  logic        shift_held;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .CLK100MHZ (clk),
    .areset    (areset),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .overflow  (overflow),
    .shift_held(shift_held),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [17:0] exp_q[$];
  bit          m_ext, m_brk, m_ovf, m_shift;
  int          m_skip;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  string shifted_digits = ")!@#$%^&*(";

  function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit shift);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code) return 8'(shift ? 65 + i : 97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code) return shift ? 8'(shifted_digits[i]) : 8'(48 + i);
    if (code == 8'h29) return 8'h20;
    if (code == 8'h5A) return 8'h0D;
    if (code == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  function automatic logic [17:0] make_event(input bit rel, input bit ext, input logic [7:0] code);
    logic [7:0] a;
    a = (ASCII_EN && !ext) ? model_ascii(code, m_shift) : 8'h00;
    if (ASCII_EN && !ext && (code == 8'h12 || code == 8'h59)) m_shift = !rel;
    return {rel, ext, a, code};
  endfunction

  function automatic logic [17:0] mask(input logic [17:0] e);
    return ASCII_EN ? e : {e[17:16], 8'h00, e[7:0]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_shift = 0; m_skip = 0;
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit rd, input bit clr);
    bit          emit, pop, drop;
    logic [17:0] ev;
    emit = 0; ev = '0;
    pop  = rd && exp_q.size() > 0;
    if (bv) begin
      if (m_skip > 0) begin
        m_skip--;
        if (m_skip == 0) begin emit = 1; ev = make_event(0, 0, 8'hE1); end
      end else if (m_brk) begin
        emit = 1; ev = make_event(1, m_ext, b); m_brk = 0; m_ext = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (m_ext) begin
        emit = 1; ev = make_event(0, 1, b); m_ext = 0;
      end else if (b == 8'hE0) begin
        m_ext = 1;
      end else if (b == 8'hE1) begin
        m_skip = 7;
      end else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF})) begin
        emit = 1; ev = make_event(0, 0, b);
      end
    end
    if (pop) void'(exp_q.pop_front());
    drop = emit && exp_q.size() == DEPTH;
    if (emit && !drop) exp_q.push_back(ev);
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    check({name, " evt_valid"}, 32'(evt_valid), 32'(exp_q.size() > 0));
    check({name, " evt_data"}, 32'(evt_data), 32'(exp_q.size() > 0 ? exp_q[0] : 18'h0));
    check({name, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({name, " shift_held"}, 32'(shift_held), 32'(m_shift));
  endtask

  // ---------------- driver tasks (entered and left at negedge) ----------------
  task automatic cycle(input bit bv, input logic [7:0] b, input bit rd, input bit clr);
    byte_valid = bv; byte_in = b; rd_en = rd; clr_ovf = clr;
    @(posedge clk);
    model_step(bv, b, rd, clr);
    @(negedge clk);
    byte_valid = 0; rd_en = 0; clr_ovf = 0;
    check_model("model");
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1, b, 0, 0);
  endtask

  task automatic do_reset();
    areset = 1; byte_valid = 1; byte_in = 8'h1C;
    @(posedge clk);
    @(negedge clk);
    areset = 0; byte_valid = 0;
    model_reset();
    check_model("reset");
    check("reset fsm_state", 32'(fsm_state), 32'd0);
  endtask

  task automatic pop_check(input string name, input logic [17:0] exp);
    check({name, " valid"}, 32'(evt_valid), 32'd1);
    check({name, " data"}, 32'(evt_data), 32'(exp));
    cycle(0, 8'h00, 1, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [23:0] bytes;
    int          n;
    bit          valid;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[16];

  logic [7:0] fill_codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
  logic [7:0] drain_codes [8] = '{8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h1C};
  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h12,
                            8'h59, 8'h1C, 8'h15, 8'h45, 8'h29, 8'h5A};

  initial begin
    vecs[0]  = '{24'h00001C, 1, 1'b1, 18'h0611C};
    vecs[1]  = '{24'h00F01C, 2, 1'b1, 18'h2611C};
    vecs[2]  = '{24'hE0F075, 3, 1'b1, 18'h30075};
    vecs[3]  = '{24'h00E075, 2, 1'b1, 18'h10075};
    vecs[4]  = '{24'h0000FA, 1, 1'b0, 18'h00000};
    vecs[5]  = '{24'h0000AA, 1, 1'b0, 18'h00000};
    vecs[6]  = '{24'h000029, 1, 1'b1, 18'h02029};
    vecs[7]  = '{24'h000045, 1, 1'b1, 18'h03045};
    vecs[8]  = '{24'h00005A, 1, 1'b1, 18'h00D5A};
    vecs[9]  = '{24'h000066, 1, 1'b1, 18'h00866};
    vecs[10] = '{24'h00E05A, 2, 1'b1, 18'h1005A};
    vecs[11] = '{24'h000000, 1, 1'b0, 18'h00000};
    vecs[12] = '{24'h000076, 1, 1'b1, 18'h00076};
    vecs[13] = '{24'h000016, 1, 1'b1, 18'h03116};
    vecs[14] = '{24'h00E0E0, 2, 1'b1, 18'h100E0};
    vecs[15] = '{24'h00F0F0, 2, 1'b1, 18'h200F0};

    @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].n; k++) begin
        logic [23:0] sh;
        sh = vecs[v].bytes >> (8 * (vecs[v].n - 1 - k));
        send(sh[7:0]);
      end
      check($sformatf("vec%0d valid", v), 32'(evt_valid), 32'(vecs[v].valid));
      check($sformatf("vec%0d data", v), 32'(evt_data),
            32'(vecs[v].valid ? mask(vecs[v].exp) : 18'h0));
    end

    // byte_valid during reset is ignored
    do_reset();
    check("reset ignores byte", 32'(evt_valid), 32'd0);

    // shift tracking
    do_reset();
    send(8'h12);
    check("shift after make", 32'(shift_held), 32'(ASCII_EN));
    send(8'h1C);
    send(8'hF0);
    check("shift before break", 32'(shift_held), 32'(ASCII_EN));
    send(8'h12);
    check("shift after break", 32'(shift_held), 32'd0);
    send(8'h1C);
    pop_check("shift ev0", 18'h00012);
    pop_check("shift ev1", mask(18'h0411C));
    pop_check("shift ev2", 18'h20012);
    pop_check("shift ev3", mask(18'h0611C));
    check("shift drained", 32'(evt_valid), 32'd0);

    // overflow and full boundary
    do_reset();
    for (int i = 0; i < 9; i++) send(fill_codes[i]);
    check("ovf set", 32'(overflow), 32'd1);
    check("ovf head", 32'(evt_data), 32'(mask(18'h07115)));
    cycle(0, 8'h00, 0, 1);
    check("ovf cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain1 %0d", i), 32'(evt_data[7:0]), 32'(fill_codes[i]));
      cycle(0, 8'h00, 1, 0);
    end
    check("drain1 empty", 32'(evt_valid), 32'd0);
    for (int i = 0; i < 8; i++) send(fill_codes[i]);
    cycle(1, 8'h1C, 1, 0);
    check("full write+pop no ovf", 32'(overflow), 32'd0);
    cycle(1, 8'h44, 0, 1);
    check("drop beats clr", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain2 %0d", i), 32'(evt_data[7:0]), 32'(drain_codes[i]));
      cycle(0, 8'h00, 1, 0);
    end
    check("drain2 empty", 32'(evt_valid), 32'd0);

    // pause sequence, then keyboard replies
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    check("pause pending", 32'(evt_valid), 32'd0);
    send(8'h77);
    send(8'h1C);
    send(8'hFA);
    send(8'hAA);
    pop_check("pause ev", 18'h000E1);
    pop_check("pause next", mask(18'h0611C));
    check("pause drained", 32'(evt_valid), 32'd0);

    // reset in the middle of a prefix
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h75);
    pop_check("midreset ev", 18'h00075);
    check("midreset drained", 32'(evt_valid), 32'd0);

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit         bv, rd, clr;
      logic [7:0] b;
      if ($urandom_range(0, 499) == 0) do_reset();
      bv  = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
      rd  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(bv, b, rd, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
